hazard_controller: RTL and testbench

Pipeline sequencing controller for the decode stage of the five-stage ARM core. Keeps a per-register write-pending scoreboard and a status-flag pending counter, and drives `i_Sig_Hazard` into the decode stage when an operand or condition is not yet valid. Also freezes the whole pipeline while the data memory is busy, raises a sticky timeout flag, flushes the wrong-path fetch and decode instructions on a taken branch, and counts stall cycles.

---
 rtl/hazard_controller_if.sv | 32 +++
 rtl/hazard_controller.sv | 110 +++++++++++
 tb/tb_hazard_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Decode-stage sequencing bundle between the pipeline and hazard_controller.
// The pipeline side drives the i_* fields; the controller answers on the o_* fields.
interface hazard_controller_if;
  logic        i_Issue_Valid;
  logic [3:0]  i_Rn;
  logic        i_Uses_Rn;
  logic [3:0]  i_Src_2;
  logic        i_Two_Src;
  logic        i_Cond_Uses_Flags;
  logic [3:0]  i_Destination;
  logic        i_Wb_Enable;
  logic        i_Status_Write_Enable;
  logic        i_Branch_Taken;
  logic        i_Mem_Busy;
  logic        o_Sig_Hazard;
  logic        o_Freeze;
  logic        o_Flush;
  logic        o_Mem_Timeout;
  logic [15:0] o_Stall_Count;

  modport master (
    output i_Issue_Valid, i_Rn, i_Uses_Rn, i_Src_2, i_Two_Src, i_Cond_Uses_Flags,
           i_Destination, i_Wb_Enable, i_Status_Write_Enable, i_Branch_Taken, i_Mem_Busy,
    input  o_Sig_Hazard, o_Freeze, o_Flush, o_Mem_Timeout, o_Stall_Count
  );

  modport slave (
    input  i_Issue_Valid, i_Rn, i_Uses_Rn, i_Src_2, i_Two_Src, i_Cond_Uses_Flags,
           i_Destination, i_Wb_Enable, i_Status_Write_Enable, i_Branch_Taken, i_Mem_Busy,
    output o_Sig_Hazard, o_Freeze, o_Flush, o_Mem_Timeout, o_Stall_Count
  );
endinterface

// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: register/flag write-pending scoreboard, memory-busy
// freeze with sticky timeout, taken-branch flush and a saturating stall-cycle counter.
module hazard_controller #(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned FLAG_DEPTH = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  localparam int unsigned CW = $clog2(PIPE_DEPTH + 1);
  localparam int unsigned FW = $clog2(FLAG_DEPTH + 1);
  localparam logic [CW-1:0] PIPE_LOAD   = CW'(PIPE_DEPTH);
  localparam logic [FW-1:0] FLAG_LOAD   = FW'(FLAG_DEPTH);
  localparam logic [15:0]   TIMEOUT_VAL = 16'(TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} mem_state_e;

  logic [CW-1:0] cnt [16];
  logic [FW-1:0] fcnt;
  logic          hazard;
  logic          freeze;
  logic          issue;

  mem_state_e    state, state_next;
  logic [15:0]   wait_cnt, wait_next;
  logic          timeout;
  logic [15:0]   stall_cnt;

  assign freeze = hz.i_Mem_Busy;

  // A flushed decode instruction never stalls, so the branch masks the hazard outright.
  assign hazard = hz.i_Issue_Valid & ~hz.i_Branch_Taken &
                  ((hz.i_Uses_Rn         & (cnt[hz.i_Rn]    != '0)) |
                   (hz.i_Two_Src         & (cnt[hz.i_Src_2] != '0)) |
                   (hz.i_Cond_Uses_Flags & (fcnt            != '0)));

  assign issue = hz.i_Issue_Valid & ~hazard & ~freeze & ~hz.i_Branch_Taken;

  assign hz.o_Sig_Hazard  = hazard;
  assign hz.o_Freeze      = freeze;
  assign hz.o_Flush       = hz.i_Branch_Taken & ~freeze;
  assign hz.o_Mem_Timeout = timeout;
  assign hz.o_Stall_Count = stall_cnt;

  // NOTE: the scoreboard is control state, not data storage, so every entry is reset;
  // a stale nonzero count after reset would stall decode on a register nobody writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
      fcnt <= '0;
    end else if (!freeze) begin
      // NOTE: non-blocking updates keep every entry reading its pre-edge value,
      // so the per-entry set/decrement decisions are independent of loop order.
      for (int i = 0; i < 16; i++) begin
        if (issue && hz.i_Wb_Enable && (hz.i_Destination == 4'(i)))
          cnt[i] <= PIPE_LOAD;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      end
      if (issue && hz.i_Status_Write_Enable)
        fcnt <= FLAG_LOAD;
      else if (fcnt != '0)
        fcnt <= fcnt - FW'(1);
    end
  end

  // The FSM only measures busy duration; the freeze itself is combinational.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    state_next = state;
    wait_next  = wait_cnt;
    case (state)
      RUN: begin
        if (hz.i_Mem_Busy) begin
          state_next = MEM_WAIT;
          wait_next  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (!hz.i_Mem_Busy) begin
          state_next = RUN;
          wait_next  = '0;
        end else if (wait_cnt != TIMEOUT_VAL) begin
          wait_next  = wait_cnt + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      // Looking at the next count raises the flag on the edge that ends the TIMEOUT-th busy cycle.
      if (wait_next == TIMEOUT_VAL)
        timeout <= 1'b1;
      if ((hazard || freeze) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic,
// compared against a ready-time model counted in unfrozen cycles.
module tb_hazard_controller;

  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned FLAG_DEPTH = 1;
  localparam int unsigned TIMEOUT    = 4;

  logic clk;
  logic reset;
  hazard_controller_if hz ();

  hazard_controller #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .FLAG_DEPTH (FLAG_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a result is readable once the count of unfrozen edges reaches its ready time.
  int unsigned u;
  int unsigned ready_u [16];
  int unsigned ready_f;
  int unsigned stall_m;
  int unsigned run_m;
  bit          timeout_m;
  bit          m_issue;
  bit          obs_hazard;
  bit          obs_freeze;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pend(input logic [3:0] r);
    return ready_u[r] > u;
  endfunction

  task automatic model_reset();
    u = 0;
    for (int i = 0; i < 16; i++) ready_u[i] = 0;
    ready_f   = 0;
    stall_m   = 0;
    run_m     = 0;
    timeout_m = 1'b0;
  endtask

  task automatic set_instr(input bit valid, input logic [3:0] rn, input bit uses_rn,
                           input logic [3:0] src2, input bit two, input bit cf,
                           input logic [3:0] dst, input bit wb, input bit s);
    hz.i_Issue_Valid         = valid;
    hz.i_Rn                  = rn;
    hz.i_Uses_Rn             = uses_rn;
    hz.i_Src_2               = src2;
    hz.i_Two_Src             = two;
    hz.i_Cond_Uses_Flags     = cf;
    hz.i_Destination         = dst;
    hz.i_Wb_Enable           = wb;
    hz.i_Status_Write_Enable = s;
  endtask

  task automatic idle();
    set_instr(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    hz.i_Branch_Taken = 1'b0;
    hz.i_Mem_Busy     = 1'b0;
  endtask

  // Called at a negedge with inputs already applied; returns at the following negedge.
  task automatic cycle();
    bit hz_m, busy, bt;
    #1;
    busy = hz.i_Mem_Busy;
    bt   = hz.i_Branch_Taken;
    hz_m = hz.i_Issue_Valid && !bt &&
           ((hz.i_Uses_Rn && pend(hz.i_Rn)) ||
            (hz.i_Two_Src && pend(hz.i_Src_2)) ||
            (hz.i_Cond_Uses_Flags && (ready_f > u)));
    check("hazard", 32'(hz.o_Sig_Hazard), 32'(hz_m));
    check("freeze", 32'(hz.o_Freeze), 32'(busy));
    check("flush",  32'(hz.o_Flush),  32'(bt && !busy));
    obs_hazard = hz.o_Sig_Hazard;
    obs_freeze = hz.o_Freeze;
    m_issue    = hz.i_Issue_Valid && !hz_m && !busy && !bt;
    @(posedge clk);
    if (!busy) begin
      u++;
      if (m_issue && hz.i_Wb_Enable)           ready_u[hz.i_Destination] = u + PIPE_DEPTH;
      if (m_issue && hz.i_Status_Write_Enable) ready_f = u + FLAG_DEPTH;
    end
    if ((hz_m || busy) && stall_m < 32'hFFFF) stall_m++;
    run_m = busy ? run_m + 1 : 0;
    if (run_m >= TIMEOUT) timeout_m = 1'b1;
    @(negedge clk);
    check("stall_count", 32'(hz.o_Stall_Count), stall_m);
    check("mem_timeout", 32'(hz.o_Mem_Timeout), 32'(timeout_m));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle();
    model_reset();
    #1;
    check("rst_hazard",  32'(hz.o_Sig_Hazard),  32'd0);
    check("rst_freeze",  32'(hz.o_Freeze),      32'd0);
    check("rst_flush",   32'(hz.o_Flush),       32'd0);
    check("rst_timeout", 32'(hz.o_Mem_Timeout), 32'd0);
    check("rst_stall",   32'(hz.o_Stall_Count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int hz_cycles, stall_cycles, freeze_cycles, j;
    bit issued;

    do_reset();

    // ADD R1 then SUB R2,R1,R3: three stall cycles.
    set_instr(1, 4'd2, 1, 4'd3, 1, 0, 4'd1, 1, 0);
    cycle();
    set_instr(1, 4'd1, 1, 4'd3, 1, 0, 4'd2, 1, 0);
    hz_cycles = 0; issued = 0;
    for (int k = 0; k < 10 && !issued; k++) begin
      cycle();
      if (obs_hazard) hz_cycles++;
      issued = m_issue;
    end
    check("dep_issued",  32'(issued), 32'd1);
    check("dep_hazards", 32'(hz_cycles), 32'd3);
    check("dep_stall",   32'(hz.o_Stall_Count), 32'd3);

    // CMP then ADDEQ: one flag stall.
    do_reset();
    set_instr(1, 4'd0, 1, 4'd0, 0, 0, 4'd0, 0, 1);
    cycle();
    set_instr(1, 4'd5, 1, 4'd0, 0, 1, 4'd6, 1, 0);
    hz_cycles = 0; issued = 0;
    for (int k = 0; k < 10 && !issued; k++) begin
      cycle();
      if (obs_hazard) hz_cycles++;
      issued = m_issue;
    end
    check("flag_issued",  32'(issued), 32'd1);
    check("flag_hazards", 32'(hz_cycles), 32'd1);

    // Dependent pair with five busy cycles in the middle of the stall.
    do_reset();
    set_instr(1, 4'd2, 1, 4'd3, 1, 0, 4'd1, 1, 0);
    cycle();
    set_instr(1, 4'd1, 1, 4'd3, 1, 0, 4'd2, 1, 0);
    stall_cycles = 0; freeze_cycles = 0; issued = 0; j = 0;
    while (j < 20 && !issued) begin
      hz.i_Mem_Busy = (j >= 1 && j <= 5);
      cycle();
      if (obs_hazard || obs_freeze) stall_cycles++;
      if (obs_freeze) freeze_cycles++;
      issued = m_issue;
      j++;
    end
    hz.i_Mem_Busy = 1'b0;
    check("frz_issued",  32'(issued), 32'd1);
    check("frz_freezes", 32'(freeze_cycles), 32'd5);
    check("frz_stalls",  32'(stall_cycles), 32'd8);
    check("frz_count",   32'(hz.o_Stall_Count), 32'd8);

    // Memory busy for six cycles with TIMEOUT=4, then idle.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      hz.i_Mem_Busy = 1'b1;
      cycle();
      check("timeout_busy", 32'(hz.o_Mem_Timeout), 32'(k >= 4));
    end
    hz.i_Mem_Busy = 1'b0;
    cycle();
    cycle();
    check("timeout_sticky", 32'(hz.o_Mem_Timeout), 32'd1);

    // Taken branch while decode holds a dependent write to R4.
    do_reset();
    set_instr(1, 4'd0, 0, 4'd0, 0, 0, 4'd5, 1, 0);
    cycle();
    set_instr(1, 4'd5, 1, 4'd0, 0, 0, 4'd4, 1, 0);
    hz.i_Branch_Taken = 1'b1;
    #1;
    check("br_flush",  32'(hz.o_Flush), 32'd1);
    check("br_hazard", 32'(hz.o_Sig_Hazard), 32'd0);
    cycle();
    hz.i_Branch_Taken = 1'b0;
    set_instr(1, 4'd4, 1, 4'd0, 0, 0, 4'd7, 0, 0);
    #1;
    check("br_r4_free", 32'(hz.o_Sig_Hazard), 32'd0);
    cycle();

    // PC is scoreboarded like any other register.
    set_instr(1, 4'd0, 0, 4'd0, 0, 0, 4'd15, 1, 0);
    cycle();
    set_instr(1, 4'd0, 0, 4'd15, 1, 0, 4'd0, 0, 0);
    #1;
    check("r15_hazard", 32'(hz.o_Sig_Hazard), 32'd1);
    cycle();

    // Reset in the middle of a stall clears the scoreboard immediately.
    do_reset();
    set_instr(1, 4'd2, 1, 4'd3, 1, 0, 4'd1, 1, 0);
    cycle();
    set_instr(1, 4'd1, 1, 4'd3, 1, 0, 4'd2, 1, 0);
    cycle();
    check("mid_pre_hazard", 32'(obs_hazard), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_hazard", 32'(hz.o_Sig_Hazard), 32'd0);
    check("mid_rst_stall",  32'(hz.o_Stall_Count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle();

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] rn, s2, dst;
      if (k == 1500) do_reset();
      rn  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      s2  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      dst = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      set_instr($urandom_range(0, 3) != 0, rn, 1'($urandom_range(0, 1)), s2,
                1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, dst,
                1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      hz.i_Branch_Taken = ($urandom_range(0, 7) == 0);
      hz.i_Mem_Busy     = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
